// File: rtl/interrupt_controller_pkg.sv
// Shared processor constants: widths, opcodes, vector base and the interrupt FSM state type.
package proc_pkg;

  localparam int unsigned NUM_IRQ  = 4;
  localparam int unsigned IRQ_ID_W = 2;
  localparam int unsigned INS_W    = 20;
  localparam int unsigned OPC_W    = 5;
  localparam int unsigned VEC_W    = 8;

  localparam logic [VEC_W-1:0] VEC_BASE = 8'hF0;

  localparam logic [OPC_W-1:0] OPC_RET = 5'b10000;
  localparam logic [OPC_W-1:0] OPC_JMP = 5'b11000;
  localparam logic [OPC_W-1:0] OPC_JC  = 5'b11100;
  localparam logic [OPC_W-1:0] OPC_JNC = 5'b11101;
  localparam logic [OPC_W-1:0] OPC_JZ  = 5'b11110;
  localparam logic [OPC_W-1:0] OPC_JNZ = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SAFE = 2'd1,
    ST_FIRE      = 2'd2,
    ST_SERVICE   = 2'd3
  } irq_state_e;

  function automatic logic is_ret(input logic [OPC_W-1:0] opc);
    return opc == OPC_RET;
  endfunction

  // All jump-class opcodes share the 2'b11 prefix.
  function automatic logic is_jump(input logic [OPC_W-1:0] opc);
    return opc[OPC_W-1 -: 2] == OPC_JMP[OPC_W-1 -: 2];
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Request/mask/pipeline inputs and interrupt outputs between the execute stage and the controller.
interface interrupt_controller_if;
  import proc_pkg::*;

  logic [NUM_IRQ-1:0]  irq_req;
  logic                mask_we;
  logic [NUM_IRQ-1:0]  mask_din;
  logic [INS_W-1:0]    ins;
  logic                pc_mux_sel;
  logic                interrupt;
  logic [IRQ_ID_W-1:0] irq_id;
  logic [VEC_W-1:0]    irq_vector;
  logic                in_service;
  logic [NUM_IRQ-1:0]  pending;

  modport master (
    output irq_req, mask_we, mask_din, ins, pc_mux_sel,
    input  interrupt, irq_id, irq_vector, in_service, pending
  );

  modport slave (
    input  irq_req, mask_we, mask_din, ins, pc_mux_sel,
    output interrupt, irq_id, irq_vector, in_service, pending
  );
endinterface

// File: rtl/interrupt_controller_priority_enc.sv
// Fixed-priority encoder: lowest set bit of the eligible vector wins.
module irq_priority_enc
  import proc_pkg::*;
(
  input  logic [NUM_IRQ-1:0]  eligible_i,
  output logic [IRQ_ID_W-1:0] idx_o,
  output logic                valid_o
);

  // Scan high to low so the lowest index overwrites last.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible_i[i]) begin
        idx_o   = IRQ_ID_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-latched, masked, fixed-priority interrupt controller that fires one pulse
// only when no control transfer is in flight and blocks until the handler's RET.
module interrupt_controller
  import proc_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  interrupt_controller_if.slave  bus
);

  irq_state_e          state_q, state_d;
  logic [NUM_IRQ-1:0]  irq_prev_q;
  logic [NUM_IRQ-1:0]  pending_q, pending_d;
  logic [NUM_IRQ-1:0]  mask_q, mask_d;
  logic [IRQ_ID_W-1:0] irq_id_q, irq_id_d;

  logic [NUM_IRQ-1:0]  edge_c;
  logic [NUM_IRQ-1:0]  clr_c;
  logic [NUM_IRQ-1:0]  eligible_c;
  logic [IRQ_ID_W-1:0] win_idx_c;
  logic                win_valid_c;
  logic [OPC_W-1:0]    opc_c;
  logic                safe_c;
  logic                unused_ins_c;

  assign opc_c        = bus.ins[INS_W-1 -: OPC_W];
  assign unused_ins_c = ^bus.ins[INS_W-OPC_W-1:0];
  assign safe_c       = ~bus.pc_mux_sel & ~is_jump(opc_c) & ~is_ret(opc_c);
  assign edge_c       = bus.irq_req & ~irq_prev_q;
  assign eligible_c   = pending_q & mask_q;

  irq_priority_enc u_prio (
    .eligible_i (eligible_c),
    .idx_o      (win_idx_c),
    .valid_o    (win_valid_c)
  );

  // Next-state, arbitration commit and grant clear.
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    clr_c    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_valid_c) begin
          irq_id_d = win_idx_c;
          state_d  = ST_WAIT_SAFE;
        end
      end
      ST_WAIT_SAFE: begin
        if (safe_c) state_d = ST_FIRE;
      end
      ST_FIRE: begin
        clr_c   = NUM_IRQ'(1) << irq_id_q;
        state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (is_ret(opc_c)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A fresh edge on the granted line in the FIRE cycle keeps its pending bit.
  assign pending_d = (pending_q & ~clr_c) | edge_c;
  assign mask_d    = bus.mask_we ? bus.mask_din : mask_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      irq_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      irq_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= bus.irq_req;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      irq_id_q   <= irq_id_d;
    end
  end

  assign bus.interrupt  = (state_q == ST_FIRE);
  assign bus.in_service = (state_q == ST_FIRE) || (state_q == ST_SERVICE);
  assign bus.irq_id     = irq_id_q;
  assign bus.irq_vector = VEC_BASE | VEC_W'({irq_id_q, 2'b00});
  assign bus.pending    = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: scoreboard of expected grants popped on each pulse.
module tb_interrupt_controller;

  localparam logic [19:0] INS_NOP = 20'h00000;
  localparam logic [19:0] INS_RET = 20'h80000;
  localparam logic [19:0] INS_JMP = 20'hC0000;
  localparam logic [19:0] INS_JZ  = 20'hF0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  interrupt_controller_if bus();

  interrupt_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks    = 0;
  int passed    = 0;
  int failed    = 0;
  int pulse_cnt = 0;
  int wide_cnt  = 0;
  logic prev_int = 1'b0;
  logic [1:0] exp_q[$];

  always @(negedge clk) begin
    if (bus.interrupt === 1'b1) begin
      pulse_cnt++;
      if (prev_int) wide_cnt++;
    end
    prev_int = (bus.interrupt === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mask(input logic [3:0] m);
    bus.mask_we  = 1'b1;
    bus.mask_din = m;
    step();
    bus.mask_we  = 1'b0;
  endtask

  // Wait (bounded) for a pulse, then compare it with the oldest scoreboard entry.
  task automatic wait_pulse(input string tag, input int exp_lat);
    int n = 0;
    logic [1:0] id;
    do begin
      step();
      n++;
    end while (bus.interrupt !== 1'b1 && n < 20);
    check({tag, " pulse"}, 32'(bus.interrupt), 32'd1);
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " scoreboard"}, 32'(exp_q.size() > 0), 32'd1);
    id = (exp_q.size() > 0) ? exp_q.pop_front() : 2'd0;
    check({tag, " irq_id"}, 32'(bus.irq_id), 32'(id));
    check({tag, " irq_vector"}, 32'(bus.irq_vector), 32'(8'hF0 | {4'b0, id, 2'b00}));
    check({tag, " in_service"}, 32'(bus.in_service), 32'd1);
  endtask

  task automatic ret_step();
    bus.ins = INS_RET;
    step();
    bus.ins = INS_NOP;
  endtask

  initial begin
    logic [19:0] hold_ins[4];
    logic        hold_pc[4];
    int          c0;

    hold_ins = '{INS_JZ, INS_NOP, INS_JMP, INS_RET};
    hold_pc  = '{1'b1, 1'b1, 1'b0, 1'b0};

    reset          = 1'b1;
    bus.irq_req    = '0;
    bus.mask_we    = 1'b0;
    bus.mask_din   = '0;
    bus.ins        = INS_NOP;
    bus.pc_mux_sel = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("reset interrupt", 32'(bus.interrupt), 32'd0);
    check("reset in_service", 32'(bus.in_service), 32'd0);
    check("reset irq_id", 32'(bus.irq_id), 32'd0);
    check("reset irq_vector", 32'(bus.irq_vector), 32'hF0);
    check("reset pending", 32'(bus.pending), 32'd0);

    // Basic service on line 0; latency 3 from the edge cycle.
    set_mask(4'b0001);
    bus.irq_req = 4'b0001;
    exp_q.push_back(2'd0);
    step();
    check("basic pending set", 32'(bus.pending), 32'h1);
    check("basic no early pulse", 32'(bus.interrupt), 32'd0);
    wait_pulse("basic", 2);
    bus.irq_req = 4'b0000;
    step();
    check("basic pulse width", 32'(bus.interrupt), 32'd0);
    check("basic in_service hold", 32'(bus.in_service), 32'd1);
    check("basic pending cleared", 32'(bus.pending), 32'd0);
    repeat (3) step();
    check("basic in_service before ret", 32'(bus.in_service), 32'd1);
    ret_step();
    check("basic in_service after ret", 32'(bus.in_service), 32'd0);
    check("basic irq_id retained", 32'(bus.irq_id), 32'd0);

    // Simultaneous edges on lines 3 and 1: line 1 first, line 3 after RET.
    set_mask(4'b1111);
    bus.irq_req = 4'b1010;
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    wait_pulse("prio first", 3);
    bus.irq_req = 4'b0000;
    step();
    check("prio line3 still pending", 32'(bus.pending), 32'h8);
    ret_step();
    wait_pulse("prio second", 2);
    step();
    ret_step();
    check("prio in_service after ret", 32'(bus.in_service), 32'd0);

    // Each unsafe pipeline condition must hold off the pulse on its own.
    bus.ins        = INS_JZ;
    bus.pc_mux_sel = 1'b1;
    bus.irq_req    = 4'b0100;
    exp_q.push_back(2'd2);
    step();
    step();
    check("holdoff wait entry", 32'(bus.interrupt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus.ins        = hold_ins[i];
      bus.pc_mux_sel = hold_pc[i];
      step();
      check($sformatf("holdoff pattern %0d", i), 32'(bus.interrupt), 32'd0);
    end
    bus.ins        = INS_NOP;
    bus.pc_mux_sel = 1'b0;
    wait_pulse("holdoff", 1);
    bus.irq_req = 4'b0000;
    step();
    ret_step();

    // Masked lines still latch; enabling the mask releases the request.
    set_mask(4'b0000);
    bus.irq_req = 4'b0100;
    step();
    check("mask pending latched", 32'(bus.pending), 32'h4);
    bus.irq_req = 4'b0000;
    c0 = pulse_cnt;
    repeat (4) step();
    check("mask no pulse", 32'(pulse_cnt), 32'(c0));
    exp_q.push_back(2'd2);
    bus.mask_we  = 1'b1;
    bus.mask_din = 4'b0100;
    step();
    bus.mask_we = 1'b0;
    wait_pulse("mask release", 2);
    step();
    ret_step();

    // New edge on the granted line during FIRE survives the clear.
    set_mask(4'b1111);
    bus.irq_req = 4'b0001;
    exp_q.push_back(2'd0);
    step();
    bus.irq_req = 4'b0000;
    wait_pulse("reedge first", 2);
    bus.irq_req = 4'b0001;
    step();
    check("reedge pending kept", 32'(bus.pending), 32'h1);
    bus.irq_req = 4'b0000;
    exp_q.push_back(2'd0);
    ret_step();
    wait_pulse("reedge second", 2);
    step();
    ret_step();

    // Reset while in SERVICE.
    bus.irq_req = 4'b0010;
    exp_q.push_back(2'd1);
    wait_pulse("rst service", 3);
    bus.irq_req = 4'b0000;
    step();
    check("rst in service", 32'(bus.in_service), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst interrupt", 32'(bus.interrupt), 32'd0);
    check("rst in_service", 32'(bus.in_service), 32'd0);
    check("rst irq_id", 32'(bus.irq_id), 32'd0);
    check("rst irq_vector", 32'(bus.irq_vector), 32'hF0);
    check("rst pending", 32'(bus.pending), 32'd0);
    c0 = pulse_cnt;
    ret_step();
    bus.irq_req = 4'b1000;
    repeat (5) step();
    check("rst no pulse after ret", 32'(pulse_cnt), 32'(c0));
    check("rst mask cleared", 32'(bus.pending), 32'h8);

    check("total pulses", 32'(pulse_cnt), 32'd8);
    check("pulse width", 32'(wide_cnt), 32'd0);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Collects four external interrupt request lines and latches edges into pending bits. Arbitrates by fixed priority under a software mask, then issues a single-cycle `interrupt` pulse to the jump control block. The pulse is only issued when no control transfer is in flight, and the controller holds off further interrupts until the service routine's RET reaches the execute stage. It sits beside the jump control block in the execute stage and is the only driver of that block's `interrupt` input. No nesting: the jump control block saves exactly one return address and one flag pair.

## Interface
- `NUM_IRQ`, 4: number of request lines (fixed at 4; `irq_id` is 2 bits).
- `VEC_BASE`, 8'hF0: base address of the interrupt vector region.

- `clk`  in  1  system clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `irq_req`  in  4  level request lines, already synchronous to `clk`; a rising edge posts a request.
- `mask_we`  in  1  write strobe for the mask register.
- `mask_din`  in  4  new mask value; bit=1 enables that line.
- `ins`  in  20  instruction currently in execute (same word the jump control block decodes).
- `pc_mux_sel`  in  1  taken-jump indication from the jump control block.
- `interrupt`  out  1  one-cycle pulse to the jump control block.
- `irq_id`  out  2  index of the line being, or last, serviced.
- `irq_vector`  out  8  `VEC_BASE | {irq_id, 2'b00}`; informational for the next jump-block revision.
- `in_service`  out  1  high from the pulse cycle until RET is seen.
- `pending`  out  4  pending bits (unmasked view).

## Operation
- **Edge latch:** `irq_prev` is a registered copy of `irq_req`. `pending[i]` sets on `irq_req[i] & ~irq_prev[i]`. Masked lines still latch.
- **Pending clear:** `pending[i]` clears in the FIRE cycle for the granted `i`. If a new edge arrives on that same line in that same cycle, set wins.
- **Eligibility:** `eligible = pending & mask`. Fixed priority: bit 0 highest. The winner is chosen when leaving IDLE, and `irq_id` is latched then. No re-arbitration in WAIT_SAFE.
- **Mask register:** reset value 4'b0000, so all lines are disabled. A write takes effect the cycle after `mask_we`.
- **Safe condition:** all three must hold:
  - `pc_mux_sel == 0`;
  - `ins[19:18] != 2'b11`, i.e. not JMP/JC/JNC/JZ/JNZ;
  - `ins[19:15] != 5'b10000`, i.e. not RET.
- **FSM:** states IDLE, WAIT_SAFE, FIRE, SERVICE.
  - IDLE: if `eligible != 0`, latch the winner into `irq_id` and go to WAIT_SAFE.
  - WAIT_SAFE: when the safe condition holds, go to FIRE. Otherwise stay.
  - FIRE: `interrupt = 1` for exactly this cycle; clear the granted pending bit; go to SERVICE.
  - SERVICE: stay until `ins[19:15] == 5'b10000`, then go to IDLE.
- **Deferred requests:** requests arriving during WAIT_SAFE, FIRE or SERVICE only set pending bits. They are arbitrated on the next IDLE.
- **RET outside SERVICE:** ignored.
- **Mask changes after selection:** clearing the mask bit of a line already selected in WAIT_SAFE does not cancel the interrupt. The selection is committed.

## Timing
- **Reset values:** state=IDLE, `pending`=0, `irq_prev`=0, mask=0, `interrupt`=0, `irq_id`=0, `irq_vector`=`VEC_BASE`, `in_service`=0.
- **Reset mid-operation:** reset in any state returns all of the above on the next edge, and any in-progress pulse is dropped.
- **Latency, best case:** edge on `irq_req` at cycle N gives `pending` set at N+1, WAIT_SAFE at N+2, FIRE (`interrupt`=1) at N+3. This holds when the line is unmasked and the pipeline is safe throughout.
- **Output timing:** `interrupt` and `in_service` are decoded from registered state, with no combinational path from inputs. `in_service` is high in FIRE and SERVICE.
- **SERVICE exit:** the cycle after RET is seen in execute, state returns to IDLE. The earliest next pulse is 3 cycles after that RET.

## Structure
- **Shared package (`proc_pkg`):**
  - opcode constants: RET=5'b10000, JMP=5'b11000, JC/JNC/JZ/JNZ = 5'b11100..11111;
  - `VEC_BASE`;
  - FSM state typedef (2-bit).
  - The jump control block reuses these opcode constants.
- **Sub-module `irq_priority_enc`:** purely combinational, 4-bit eligible in → 2-bit index plus valid out. The FSM, edge latch and mask live in `interrupt_controller`.

## Test plan
- **Basic service:** mask=4'b0001, pulse `irq_req[0]`, `ins`=NOP, `pc_mux_sel`=0 → `interrupt` high exactly 1 cycle at N+3; `irq_id`=0; `irq_vector`=8'hF0. `in_service` holds until RET is driven, then drops the next cycle.
- **Priority:** mask=4'b1111, edges on lines 3 and 1 in the same cycle → line 1 serviced first (`irq_vector`=8'hF4). After RET, line 3 is serviced (8'hFC).
- **Unsafe hold-off:** a request arrives while `ins`=JZ, `pc_mux_sel`=1 for 3 cycles → no pulse until the first safe cycle, then `interrupt` pulses once.
- **Masking:** mask=0, edge on line 2 → `pending`=4'b0100 and no pulse. Write mask=4'b0100 → pulse 3 cycles after the write.
- **Re-edge during FIRE:** a new rising edge on the granted line in the FIRE cycle → `pending` bit stays set and a second service follows after RET.
- **Reset mid-service:** assert `reset` in SERVICE → next cycle all outputs at reset values. A following RET produces no pulse.
